// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared encodings and helpers for the pipeline control slice    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package pipe_pkg;

    localparam int REG_W = 3;
    localparam int CNT_W = 8;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_LD   = 5'b10001;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dff : W-bit register with asynchronous active-low clear to RESET_VAL      |
// | Rev 1.1                                                                   |
// +--------------------------------------------------------------------------+
module dff #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_detect : decode-vs-execute register match for load-use hazards     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hazard_detect
    import pipe_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic             i_dec_valid,
    input  logic [REG_W-1:0] i_dec_rs,
    input  logic [REG_W-1:0] i_dec_rt,
    input  logic             i_uses_rs,
    input  logic             i_uses_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_wreg,
    output logic             o_hit
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_uses_rs && (i_dec_rs == i_ex_wreg);
    assign w_rt_match = i_uses_rt && (i_dec_rt == i_ex_wreg);
    assign o_hit      = ENABLE && i_dec_valid && i_ex_valid && i_ex_memread
                        && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_ctrl : stall/flush scheduler for the five-stage pipeline         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 3,
    parameter int MEM_TIMEOUT    = 255,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Dec_valid,
    input  logic [REG_W-1:0] Dec_rs,
    input  logic [REG_W-1:0] Dec_rt,
    input  logic             Dec_uses_rs,
    input  logic             Dec_uses_rt,
    input  logic             Dec_halt,
    input  logic             Dec_siic,
    input  logic             Ex_valid,
    input  logic             Ex_memread,
    input  logic [REG_W-1:0] Ex_wreg,
    input  logic             Ex_redirect,
    input  logic             Mem_busy,
    output logic             Pc_stall,
    output logic             Ifid_stall,
    output logic             Ifid_flush,
    output logic             Idex_bubble,
    output logic             Exmem_stall,
    output logic             Halted,
    output logic             Err,
    output logic [1:0]       State
);

    localparam logic [CNT_W-1:0] c_MEM_TO = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_DRAIN  = CNT_W'(DRAIN_CYCLES);

    logic [1:0]       r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_mem_cnt,   w_mem_nxt,   w_mem_inc;
    logic [CNT_W-1:0] r_drain_cnt, w_drain_nxt, w_drain_inc;
    logic             r_pending,   w_pend_nxt;
    logic             r_err,       w_err_nxt;
    logic             r_halted,    w_halted_nxt;
    logic             w_lu;
    logic             w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_bubble, w_exmem_stall;

    hazard_detect #(.ENABLE(LOAD_USE_STALL)) u_hazard (
        .i_dec_valid  (Dec_valid),
        .i_dec_rs     (Dec_rs),
        .i_dec_rt     (Dec_rt),
        .i_uses_rs    (Dec_uses_rs),
        .i_uses_rt    (Dec_uses_rt),
        .i_ex_valid   (Ex_valid),
        .i_ex_memread (Ex_memread),
        .i_ex_wreg    (Ex_wreg),
        .o_hit        (w_lu)
    );

    assign w_mem_inc   = sat_inc(r_mem_cnt);
    assign w_drain_inc = sat_inc(r_drain_cnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_mem_nxt     = r_mem_cnt;
        w_drain_nxt   = r_drain_cnt;
        w_pend_nxt    = r_pending;
        w_err_nxt     = r_err;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_stall = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (Mem_busy) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_exmem_stall = 1'b1;
                    w_pend_nxt    = Ex_redirect;
                    w_mem_nxt     = CNT_W'(1);
                    w_state_nxt   = ST_MEM_WAIT;
                    if (CNT_W'(1) >= c_MEM_TO) w_err_nxt = 1'b1;
                end else if (Ex_redirect) begin
                    // Decode holds a wrong-path instruction, so lu/halt/siic are moot.
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (Dec_siic && Dec_valid) begin
                    w_ifid_flush  = 1'b1;
                end else if (Dec_halt && Dec_valid) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_drain_nxt   = '0;
                    w_state_nxt   = ST_DRAIN;
                end else if (w_lu) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (Mem_busy) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_exmem_stall = 1'b1;
                    w_pend_nxt    = r_pending | Ex_redirect;
                    w_mem_nxt     = w_mem_inc;
                    if (w_mem_inc >= c_MEM_TO) w_err_nxt = 1'b1;
                end else begin
                    w_ifid_flush  = r_pending | Ex_redirect;
                    w_idex_bubble = r_pending | Ex_redirect;
                    w_pend_nxt    = 1'b0;
                    w_mem_nxt     = '0;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_DRAIN: begin
                w_pc_stall   = 1'b1;
                w_ifid_flush = 1'b1;
                if (Mem_busy) begin
                    w_exmem_stall = 1'b1;
                end else if (Ex_redirect) begin
                    // An older branch proves the HALT was speculative: resume at the target.
                    w_pc_stall    = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_drain_nxt = w_drain_inc;
                    if (w_drain_inc >= c_DRAIN) w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_exmem_stall = 1'b1;
            end
        endcase
    end

    assign w_halted_nxt = r_halted | (w_state_nxt == ST_HALTED);

    dff #(.W(2), .RESET_VAL(ST_RUN)) u_state_ff (
        .clk(clk), .rst_n(rst), .i_d(w_state_nxt), .o_q(r_state));
    dff #(.W(CNT_W)) u_mem_cnt_ff (
        .clk(clk), .rst_n(rst), .i_d(w_mem_nxt), .o_q(r_mem_cnt));
    dff #(.W(CNT_W)) u_drain_cnt_ff (
        .clk(clk), .rst_n(rst), .i_d(w_drain_nxt), .o_q(r_drain_cnt));
    dff #(.W(1)) u_pending_ff (
        .clk(clk), .rst_n(rst), .i_d(w_pend_nxt), .o_q(r_pending));
    dff #(.W(1)) u_err_ff (
        .clk(clk), .rst_n(rst), .i_d(w_err_nxt), .o_q(r_err));
    dff #(.W(1)) u_halted_ff (
        .clk(clk), .rst_n(rst), .i_d(w_halted_nxt), .o_q(r_halted));

    // Reset overrides the FSM: PC held, every other enable quiet.
    assign Pc_stall    = ~rst | w_pc_stall;
    assign Ifid_stall  = rst & w_ifid_stall;
    assign Ifid_flush  = rst & w_ifid_flush;
    assign Idex_bubble = rst & w_idex_bubble;
    assign Exmem_stall = rst & w_exmem_stall;
    assign Halted      = r_halted;
    assign Err         = r_err;
    assign State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_ctrl : directed self-checking bench for pipeline_ctrl         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Dec_valid, Dec_uses_rs, Dec_uses_rt, Dec_halt, Dec_siic;
    logic [2:0] Dec_rs, Dec_rt, Ex_wreg;
    logic       Ex_valid, Ex_memread, Ex_redirect, Mem_busy;

    logic       Pc_stall, Ifid_stall, Ifid_flush, Idex_bubble, Exmem_stall, Halted, Err;
    logic [1:0] State;
    logic       n_pc, n_ifs, n_iff, n_bub, n_exm, n_halted, n_err;
    logic [1:0] n_state;

    logic [4:0] ctl, ctl_nolu;
    assign ctl      = {Pc_stall, Ifid_stall, Ifid_flush, Idex_bubble, Exmem_stall};
    assign ctl_nolu = {n_pc, n_ifs, n_iff, n_bub, n_exm};

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipeline_ctrl u_dut (
        .clk(clk), .rst(rst),
        .Dec_valid(Dec_valid), .Dec_rs(Dec_rs), .Dec_rt(Dec_rt),
        .Dec_uses_rs(Dec_uses_rs), .Dec_uses_rt(Dec_uses_rt),
        .Dec_halt(Dec_halt), .Dec_siic(Dec_siic),
        .Ex_valid(Ex_valid), .Ex_memread(Ex_memread), .Ex_wreg(Ex_wreg),
        .Ex_redirect(Ex_redirect), .Mem_busy(Mem_busy),
        .Pc_stall(Pc_stall), .Ifid_stall(Ifid_stall), .Ifid_flush(Ifid_flush),
        .Idex_bubble(Idex_bubble), .Exmem_stall(Exmem_stall),
        .Halted(Halted), .Err(Err), .State(State)
    );

    pipeline_ctrl #(.LOAD_USE_STALL(1'b0)) u_dut_nolu (
        .clk(clk), .rst(rst),
        .Dec_valid(Dec_valid), .Dec_rs(Dec_rs), .Dec_rt(Dec_rt),
        .Dec_uses_rs(Dec_uses_rs), .Dec_uses_rt(Dec_uses_rt),
        .Dec_halt(Dec_halt), .Dec_siic(Dec_siic),
        .Ex_valid(Ex_valid), .Ex_memread(Ex_memread), .Ex_wreg(Ex_wreg),
        .Ex_redirect(Ex_redirect), .Mem_busy(Mem_busy),
        .Pc_stall(n_pc), .Ifid_stall(n_ifs), .Ifid_flush(n_iff),
        .Idex_bubble(n_bub), .Exmem_stall(n_exm),
        .Halted(n_halted), .Err(n_err), .State(n_state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        Dec_valid = 0; Dec_rs = 0; Dec_rt = 0; Dec_uses_rs = 0; Dec_uses_rt = 0;
        Dec_halt = 0; Dec_siic = 0; Ex_valid = 0; Ex_memread = 0; Ex_wreg = 0;
        Ex_redirect = 0; Mem_busy = 0;
    endtask

    // Inputs change at the falling edge; everything is sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    // ctl bit order: {Pc_stall, Ifid_stall, Ifid_flush, Idex_bubble, Exmem_stall}
    initial begin
        idle();
        #2 rst = 1'b0;
        #2;
        chk("rst_async_state", State, 2'd0);
        chk("rst_ctl", ctl, 5'b10000);
        step(); Mem_busy = 1; #1;
        chk("rst_ctl_busy", ctl, 5'b10000);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_err", Err, 1'b0);
        step(); idle(); rst = 1'b1;

        // Load-use on rs: LD R3 in execute, ADD reading R3 in decode.
        step(); Dec_valid = 1; Dec_rs = 3; Dec_uses_rs = 1;
        Ex_valid = 1; Ex_memread = 1; Ex_wreg = 3; #1;
        chk("lu_rs", ctl, 5'b11010);
        chk("lu_rs_nostall_cfg", ctl_nolu, 5'b00000);
        step(); Ex_valid = 0; Ex_memread = 0; #1;
        chk("lu_cleared", ctl, 5'b00000);
        chk("lu_state", State, 2'd0);
        step(); Dec_uses_rs = 0; Dec_uses_rt = 1; Dec_rt = 5;
        Ex_valid = 1; Ex_memread = 1; Ex_wreg = 5; #1;
        chk("lu_rt", ctl, 5'b11010);
        step(); Ex_wreg = 4; #1;
        chk("lu_rt_nomatch", ctl, 5'b00000);
        step(); Dec_rs = 4; Dec_uses_rs = 0; Dec_uses_rt = 0; #1;
        chk("lu_rs_unused", ctl, 5'b00000);

        // Redirect squashes decode: overrides lu and HALT.
        step(); Dec_uses_rs = 1; Dec_halt = 1; Ex_redirect = 1; #1;
        chk("redir_ctl", ctl, 5'b00110);
        step(); idle(); #1;
        chk("redir_state", State, 2'd0);
        chk("redir_after", ctl, 5'b00000);

        step(); Dec_valid = 1; Dec_siic = 1; #1;
        chk("siic_ctl", ctl, 5'b00100);

        // Memory wait with a redirect in the first busy cycle.
        step(); idle(); Mem_busy = 1; Ex_redirect = 1; #1;
        chk("mw_first", ctl, 5'b11001);
        for (int i = 2; i <= 5; i++) begin
            step(); Ex_redirect = 0; #1;
            chk("mw_hold", ctl, 5'b11001);
            chk("mw_state", State, 2'd1);
        end
        step(); Mem_busy = 0; #1;
        chk("mw_release", ctl, 5'b00110);
        step(); #1;
        chk("mw_back_run", State, 2'd0);
        chk("mw_no_flush", ctl, 5'b00000);

        // HALT cancelled by an older redirect while draining.
        step(); Dec_valid = 1; Dec_halt = 1; #1;
        chk("halt_ctl", ctl, 5'b10100);
        step(); idle(); Ex_redirect = 1; #1;
        chk("drain_redir_state", State, 2'd2);
        chk("drain_redir_ctl", ctl, 5'b00110);
        step(); idle(); #1;
        chk("drain_redir_run", State, 2'd0);

        // Memory timeout: Err appears after the 255th busy edge.
        for (int i = 1; i <= 256; i++) begin
            step(); Mem_busy = 1; #1;
            if (i == 255) chk("to_err_pre", Err, 1'b0);
            if (i == 256) begin
                chk("to_err_set", Err, 1'b1);
                chk("to_ctl", ctl, 5'b11001);
            end
        end
        step(); Mem_busy = 0; #1;
        chk("to_release", ctl, 5'b00000);
        chk("to_err_sticky", Err, 1'b1);
        step(); #1;
        chk("to_err_run", Err, 1'b1);
        chk("to_state_run", State, 2'd0);
        #2 rst = 1'b0; #1;
        chk("to_err_cleared", Err, 1'b0);
        step(); rst = 1'b1;

        // Asynchronous reset in the middle of a memory wait.
        step(); Mem_busy = 1;
        step(); #1;
        chk("ar_in_mw", State, 2'd1);
        #2 rst = 1'b0; #1;
        chk("ar_state", State, 2'd0);
        chk("ar_err", Err, 1'b0);
        chk("ar_ctl", ctl, 5'b10000);
        step(); Mem_busy = 0; rst = 1'b1;

        // HALT drain: three DRAIN cycles, then HALTED for good.
        step(); Dec_valid = 1; Dec_halt = 1; #1;
        chk("h_decode", ctl, 5'b10100);
        for (int i = 1; i <= 3; i++) begin
            step(); idle(); #1;
            chk("h_drain_state", State, 2'd2);
            chk("h_drain_ctl", ctl, 5'b10100);
            chk("h_not_halted", Halted, 1'b0);
        end
        step(); #1;
        chk("h_state", State, 2'd3);
        chk("h_halted", Halted, 1'b1);
        chk("h_ctl", ctl, 5'b11001);
        step(); Ex_redirect = 1; Dec_valid = 1; Dec_siic = 1; #1;
        chk("h_ignore_ctl", ctl, 5'b11001);
        step(); #1;
        chk("h_ignore_state", State, 2'd3);
        chk("h_ignore_halted", Halted, 1'b1);
        #2 rst = 1'b0; #1;
        chk("h_rst_halted", Halted, 1'b0);
        chk("h_rst_state", State, 2'd0);
        step(); idle(); rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the five-stage pipeline. It sits beside decode and drives the freeze, bubble and flush enables of the PC, IF/ID, ID/EX and EX/MEM registers.
- Arbitrates between four event sources: execute-stage redirects (branch/jump/RTI), data-memory busy, load-use hazards, and the HALT instruction.
- Sequences the multi-cycle cases (memory wait, halt drain) with a small FSM and counters.

Parameters:
- DRAIN_CYCLES, 3: cycles after HALT decode before Halted asserts (lets older instructions retire).
- MEM_TIMEOUT, 255: maximum consecutive Mem_busy cycles before Err is raised.
- LOAD_USE_STALL, 1: 1 = insert a one-cycle bubble on load-use; 0 = no bubble (memory-forwarding path covers it).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Dec_valid  in  1  decode holds a valid instruction.
- Dec_rs  in  3  decode source register 1 (Instruction[10:8]).
- Dec_rt  in  3  decode source register 2 (Instruction[7:5]).
- Dec_uses_rs  in  1  decode instruction reads rs.
- Dec_uses_rt  in  1  decode instruction reads rt (R-format, or ST/STU data).
- Dec_halt  in  1  decode instruction is HALT.
- Dec_siic  in  1  decode instruction is SIIC (exception entry).
- Ex_valid  in  1  execute holds a valid instruction.
- Ex_memread  in  1  execute instruction is a load.
- Ex_wreg  in  3  execute destination register.
- Ex_redirect  in  1  execute resolved a taken branch/jump/RTI.
- Mem_busy  in  1  data memory not ready this cycle.
- Pc_stall  out  1  hold PC.
- Ifid_stall  out  1  hold IF/ID.
- Ifid_flush  out  1  load NOP into IF/ID.
- Idex_bubble  out  1  load NOP into ID/EX.
- Exmem_stall  out  1  hold EX/MEM and MEM/WB.
- Halted  out  1  sticky; processor halted.
- Err  out  1  sticky; memory timeout.
- State  out  2  FSM state, for debug.

Behaviour:
- rst low: State = RUN, counters = 0, pending_redirect = 0, Halted = 0, Err = 0.
- While rst is low, Pc_stall = 1 and all other control outputs = 0.
- Stall/flush outputs are combinational from state and inputs. Halted, Err and State are registered.
- Load-use condition, lu: LOAD_USE_STALL & Dec_valid & Ex_valid & Ex_memread & ((Dec_uses_rs & Dec_rs == Ex_wreg) | (Dec_uses_rt & Dec_rt == Ex_wreg)).
- FSM states: RUN = 0, MEM_WAIT = 1, DRAIN = 2, HALTED = 3.
- RUN, output priority (highest first):
  - Mem_busy: Pc_stall = Ifid_stall = Exmem_stall = 1, Idex_bubble = 0. If Ex_redirect is also high, set pending_redirect. Next state MEM_WAIT, memory counter = 1.
  - Ex_redirect: Ifid_flush = 1, Idex_bubble = 1, PC free (loads the target). This overrides lu, Dec_halt and Dec_siic, because the decode instruction is squashed.
  - Dec_siic & Dec_valid: Ifid_flush = 1 for one cycle; the SIIC itself proceeds.
  - Dec_halt & Dec_valid: Pc_stall = 1, Ifid_flush = 1. Next state DRAIN, drain counter = 0.
  - lu: Pc_stall = Ifid_stall = 1, Idex_bubble = 1 for exactly one cycle. The next cycle sees Ex_memread = 0, so lu clears without extra state.
- MEM_WAIT:
  - Pc_stall, Ifid_stall and Exmem_stall stay at 1 while Mem_busy is high. The memory counter increments each cycle.
  - If the counter reaches MEM_TIMEOUT: set Err (sticky until reset). The FSM stays in MEM_WAIT until Mem_busy falls.
  - First cycle with Mem_busy low: all stalls release. If pending_redirect is set, assert Ifid_flush and Idex_bubble and clear pending_redirect. Next state RUN.
- DRAIN:
  - Pc_stall = 1 and Ifid_flush = 1 every cycle. The drain counter increments only when Mem_busy is low; while Mem_busy is high, Exmem_stall = 1.
  - A redirect in DRAIN (an older branch) is obeyed: flush as in RUN, then return to RUN. The HALT was on the wrong path.
  - When the counter reaches DRAIN_CYCLES: next state HALTED.
- HALTED: Halted = 1; Pc_stall = Ifid_stall = Exmem_stall = 1; all inputs ignored until reset.
- Counters are 8-bit and saturate; they never wrap.

Decomposition:
- Shared package pipe_pkg:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALTED;
  - opcode constants OP_HALT = 5'b00000, OP_SIIC = 5'b00010, OP_LD = 5'b10001 (used by the decode glue that generates the Dec_* flags).
- Sub-module hazard_detect: the combinational lu comparator, reusable for forwarding checks.
- State and counter flops use the existing dff cell, extended with an asynchronous active-low clear.

Test Plan:
1. LD R3 in execute, ADD with Dec_rs = 3 and Dec_uses_rs = 1 in decode -> exactly one cycle of Pc_stall = Ifid_stall = Idex_bubble = 1. Repeat with LOAD_USE_STALL = 0 -> no stall.
2. Ex_redirect = 1 together with lu = 1 and Dec_halt = 1 -> Ifid_flush = Idex_bubble = 1, Pc_stall = 0, State stays 0.
3. Mem_busy high for 5 cycles, Ex_redirect pulsed in the first cycle -> stalls held 5 cycles. On the release cycle Ifid_flush = Idex_bubble = 1, then State = 0.
4. Mem_busy held 256 cycles -> Err rises at cycle 255 and stays 1 after Mem_busy drops, until rst is pulsed low.
5. HALT decoded, Mem_busy low -> State = 2 for 3 cycles, then Halted = 1 and State = 3. Inputs ignored afterwards.
6. rst driven low mid-MEM_WAIT (asynchronous, between clock edges) -> State = 0, Err = 0, Pc_stall = 1 immediately.
